// File: rtl/tracking_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tracking_pkg
//  Brief    : Shared types and defaults for the tracking / overlay stages.
//  Revision : 1.0  initial release
// ============================================================================
package tracking_pkg;

  // Default geometry; the overlay and bounds blocks take these as parameter
  // defaults so a bench or a different sensor can override them.
  localparam int DEF_COORD_W = 12;
  localparam int DEF_WIDTH   = 720;
  localparam int DEF_HEIGHT  = 540;

  // Box as reported by tracking: center plus full extent.
  typedef struct packed {
    logic [DEF_COORD_W-1:0] cx;
    logic [DEF_COORD_W-1:0] cy;
    logic [DEF_COORD_W-1:0] w;
    logic [DEF_COORD_W-1:0] h;
  } box_t;

  // Inclusive clamped rectangle; one extra bit so cx+hw cannot overflow.
  typedef struct packed {
    logic [DEF_COORD_W:0] x0;
    logic [DEF_COORD_W:0] x1;
    logic [DEF_COORD_W:0] y0;
    logic [DEF_COORD_W:0] y1;
  } bounds_t;

  typedef enum logic [0:0] {
    S_PASS = 1'b0,
    S_DRAW = 1'b1
  } state_t;

endpackage : tracking_pkg
`default_nettype wire

// File: rtl/box_bounds.sv
`default_nettype none
// ============================================================================
//  Module   : box_bounds
//  Brief    : Combinational center/size box to clamped inclusive rectangle,
//             with a flag for boxes that must not be drawn.
//  Revision : 1.0  initial release
// ============================================================================
module box_bounds
  import tracking_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  box_t    box_i,
  output bounds_t bounds_o,
  output logic    empty_o
);

  localparam int BW = DEF_COORD_W + 1;
  localparam logic [BW-1:0] X_MAX = BW'(WIDTH - 1);
  localparam logic [BW-1:0] Y_MAX = BW'(HEIGHT - 1);

  logic [BW-1:0] w_cx, w_cy, w_hw, w_hh, w_xe, w_ye;

  assign w_cx = {1'b0, box_i.cx};
  assign w_cy = {1'b0, box_i.cy};
  assign w_hw = {1'b0, box_i.w} >> 1;
  assign w_hh = {1'b0, box_i.h} >> 1;
  assign w_xe = w_cx + w_hw;
  assign w_ye = w_cy + w_hh;

  // Clamp each edge into the frame; the near edge saturates at zero.
  always_comb begin
    bounds_o    = '0;
    bounds_o.x0 = (w_cx >= w_hw) ? (w_cx - w_hw) : '0;
    bounds_o.x1 = (w_xe > X_MAX) ? X_MAX : w_xe;
    bounds_o.y0 = (w_cy >= w_hh) ? (w_cy - w_hh) : '0;
    bounds_o.y1 = (w_ye > Y_MAX) ? Y_MAX : w_ye;
  end

  // Zero-size boxes and centers outside the frame are not drawn at all.
  assign empty_o = (box_i.w == '0) || (box_i.h == '0) ||
                   (w_cx > X_MAX) || (w_cy > Y_MAX);

endmodule : box_bounds
`default_nettype wire

// File: rtl/bbox_overlay.sv
`default_nettype none
// ============================================================================
//  Module   : bbox_overlay
//  Brief    : FIFO-to-FIFO pixel pass-through that paints the outline of the
//             most recent tracking box onto the raster.
//  Revision : 1.0  initial release
// ============================================================================
module bbox_overlay
  import tracking_pkg::*;
#(
  parameter int          WIDTH     = DEF_WIDTH,
  parameter int          HEIGHT    = DEF_HEIGHT,
  parameter int          COORD_W   = DEF_COORD_W,
  parameter int          THICK     = 2,
  parameter logic [23:0] BOX_COLOR = 24'h00FF00
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_empty,
  output logic               in_rd_en,
  input  logic [23:0]        in_dout,
  input  logic               out_full,
  output logic               out_wr_en,
  output logic [23:0]        out_din,
  input  logic               box_valid,
  input  logic [COORD_W-1:0] center_x,
  input  logic [COORD_W-1:0] center_y,
  input  logic [COORD_W-1:0] width,
  input  logic [COORD_W-1:0] height,
  output logic               box_active
);

  localparam logic [COORD_W-1:0] X_LAST  = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] Y_LAST  = COORD_W'(HEIGHT - 1);
  localparam int                 EW      = COORD_W + 2;
  localparam logic [EW-1:0]      T_EXT   = EW'(THICK);

  generate
    if ((THICK < 1) || (THICK > 8) || (COORD_W != DEF_COORD_W)) begin : g_param_check
      $error("bbox_overlay: unsupported THICK or COORD_W");
    end
  endgenerate

  // Raster position of the pixel currently at the head of the input FIFO.
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;

  // Latest strobed box (pending) and the box applied to the current frame.
  box_t               pend_q, pend_d;
  logic               pflag_q, pflag_d;
  box_t               act_q, act_d;
  state_t             state_q, state_d;

  logic               w_xfer;
  logic               w_fstart;
  logic               w_apply;
  box_t               w_sel_box;
  bounds_t            w_bnd;
  logic               w_empty;
  logic               w_draw;
  logic [EW-1:0]      w_px, w_py, w_x0, w_x1, w_y0, w_y1;
  logic               w_inside;
  logic               w_edge;

  // A pixel moves whenever both FIFOs allow it; reset blocks the pop.
  assign w_xfer    = !in_empty && !out_full && !reset;
  assign in_rd_en  = w_xfer;
  assign out_wr_en = w_xfer;

  assign w_fstart  = w_xfer && (x_q == '0) && (y_q == '0);
  // A pending box takes over at the first pixel of a frame, so that pixel
  // has to be judged against the pending box rather than the active one.
  assign w_apply   = w_fstart && pflag_q;
  assign w_sel_box = w_apply ? pend_q : act_q;

  box_bounds #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT)
  ) u_bounds (
    .box_i    (w_sel_box),
    .bounds_o (w_bnd),
    .empty_o  (w_empty)
  );

  assign w_draw = w_apply ? !w_empty : (state_q == S_DRAW);

  // Raster counter next state: advance only on a transfer, wrap per line/frame.
  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (w_xfer) begin
      if (x_q == X_LAST) begin
        x_d = '0;
        y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Raster counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  // Pending box capture; a strobe on the frame-start pixel re-arms the flag
  // so it waits for the following frame.
  always_comb begin
    pend_d  = pend_q;
    pflag_d = pflag_q;
    if (w_apply) begin
      pflag_d = 1'b0;
    end
    if (box_valid) begin
      pend_d.cx = center_x;
      pend_d.cy = center_y;
      pend_d.w  = width;
      pend_d.h  = height;
      pflag_d   = 1'b1;
    end
  end

  // FSM next state and active box: only a frame-start with a pending box
  // changes anything.
  always_comb begin
    state_d = state_q;
    act_d   = act_q;
    if (w_apply) begin
      act_d   = pend_q;
      state_d = w_empty ? S_PASS : S_DRAW;
    end
  end

  // Box registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend_q  <= '0;
      pflag_q <= 1'b0;
      act_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      pflag_q <= pflag_d;
      act_q   <= act_d;
    end
  end

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_PASS;
    end else begin
      state_q <= state_d;
    end
  end

  assign box_active = (state_q == S_DRAW);

  // Outline test in widened arithmetic so x+THICK cannot wrap.
  assign w_px = {2'b00, x_q};
  assign w_py = {2'b00, y_q};
  assign w_x0 = {1'b0, w_bnd.x0};
  assign w_x1 = {1'b0, w_bnd.x1};
  assign w_y0 = {1'b0, w_bnd.y0};
  assign w_y1 = {1'b0, w_bnd.y1};

  assign w_inside = (w_px >= w_x0) && (w_px <= w_x1) &&
                    (w_py >= w_y0) && (w_py <= w_y1);
  assign w_edge   = (w_px < (w_x0 + T_EXT)) || ((w_px + T_EXT) > w_x1) ||
                    (w_py < (w_y0 + T_EXT)) || ((w_py + T_EXT) > w_y1);

  // Output pixel: box color on the outline ring, otherwise pass-through.
  always_comb begin
    out_din = in_dout;
    if (w_draw && w_inside && w_edge) begin
      out_din = BOX_COLOR;
    end
  end

endmodule : bbox_overlay
`default_nettype wire
